bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 47 ++++
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Purpose  : Shared state encoding and default sizing for the bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  localparam int C_DEF_N        = 4;
  localparam int C_DEF_MAX_HOLD = 8;

  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_TURN = 2'b01;
  localparam logic [1:0] C_OWN  = 2'b10;

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector starting after last_owner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = C_DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_owner,
  input  logic [N-1:0]         exclude,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  localparam int W = $clog2(N);

  logic [N-1:0] w_cand;
  logic [W-1:0] w_idx;
  int           w_sum;

  assign w_cand = req & ~exclude;

  // Walk last_owner+1 .. last_owner+N modulo N; the first hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    w_sum = 0;
    w_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = int'(last_owner) + k;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_idx = W'(w_sum);
      if (!found && w_cand[w_idx]) begin
        found = 1'b1;
        index = w_idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin owner arbiter for a shared tri-stated bus with a
//            one-cycle turnaround and a bounded hold time.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N        = C_DEF_N,
  parameter int MAX_HOLD = C_DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         switch,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int         W           = $clog2(N);
  localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N-1:0] C_ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   r_state;
  logic [W-1:0] r_pending;
  logic [W-1:0] r_last_owner;
  logic [W-1:0] r_owner;
  logic [7:0]   r_cnt;
  logic [N-1:0] r_grant;
  logic         r_busy;

  logic         w_owner_req;
  logic         w_others;
  logic         w_timeout;
  logic [N-1:0] w_exclude;
  logic         w_found;
  logic [W-1:0] w_pick;

  assign w_owner_req = req[r_owner];
  assign w_others    = |(req & ~r_grant);
  assign w_timeout   = (r_state == C_OWN) && w_owner_req &&
                       (r_cnt == C_HOLD_LAST) && w_others;
  // Only a forced hand-off keeps the current owner out of the next pick.
  assign w_exclude   = w_timeout ? r_grant : '0;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_last_owner),
    .exclude    (w_exclude),
    .found      (w_found),
    .index      (w_pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= C_IDLE;
      r_pending    <= '0;
      r_last_owner <= W'(N - 1);
      r_owner      <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_found) begin
            r_state   <= C_TURN;
            r_pending <= w_pick;
          end
        end
        C_TURN: begin
          if (req[r_pending]) begin
            r_state      <= C_OWN;
            r_grant      <= C_ONE << r_pending;
            r_owner      <= r_pending;
            r_last_owner <= r_pending;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
          end else begin
            r_state <= C_IDLE;
          end
        end
        C_OWN: begin
          if (!w_owner_req || w_timeout) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            if (w_found) begin
              r_state   <= C_TURN;
              r_pending <= w_pick;
            end else begin
              r_state <= C_IDLE;
            end
          end else if (r_cnt != C_HOLD_LAST) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= C_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer enables come straight from the one-hot grant register.
  assign switch = ~r_grant;
  assign grant  = r_grant;
  assign owner  = r_owner;
  assign busy   = r_busy;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] switch;
  logic [1:0]   owner;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .grant  (grant),
    .switch (switch),
    .owner  (owner),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus-safety invariant sampled every cycle.
  always @(negedge clk) begin
    check("one_driver", {31'd0, ($countones(~switch) <= 1)}, 32'd1);
    if (busy) check("grant_eq_nswitch", {28'd0, grant}, {28'd0, ~switch});
  end

  // ---------------- behavioural model ----------------
  int m_mode;   // 0 idle, 1 turnaround, 2 owned
  int m_pend;
  int m_owner;
  int m_last;
  int m_hold;

  function automatic int rr(input logic [N-1:0] r, input int last, input int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_owner = 0; m_last = N - 1; m_hold = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int p;
    case (m_mode)
      0: begin
        p = rr(r, m_last, -1);
        if (p >= 0) begin m_mode = 1; m_pend = p; end
      end
      1: begin
        if (r[m_pend]) begin
          m_mode = 2; m_owner = m_pend; m_last = m_pend; m_hold = 0;
        end else m_mode = 0;
      end
      default: begin
        if (!r[m_owner]) begin
          p = rr(r, m_last, -1);
          if (p >= 0) begin m_mode = 1; m_pend = p; end
          else m_mode = 0;
        end else if (m_hold == MAX_HOLD - 1 && (r & ~(N'(1) << m_owner)) != 0) begin
          m_mode = 1; m_pend = rr(r, m_last, m_owner);
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold++;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0;
    #1;
    check("rst_grant",  {28'd0, grant},  32'h0);
    check("rst_switch", {28'd0, switch}, 32'hF);
    check("rst_busy",   {31'd0, busy},   32'h0);
    check("rst_owner",  {30'd0, owner},  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // req, expected grant, busy, owner (after the following rising edge)
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{4'b0010, 4'b0000, 1'b0, 2'd0};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
    tbl[9]  = '{4'b0100, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[11] = '{4'b1001, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{4'b1001, 4'b1000, 1'b1, 2'd3};
    tbl[13] = '{4'b0001, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{4'b0001, 4'b0001, 1'b1, 2'd0};

    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req;
      tick();
      check($sformatf("vec%0d_grant", i),  {28'd0, grant},  {28'd0, tbl[i].grant});
      check($sformatf("vec%0d_switch", i), {28'd0, switch}, {28'd0, ~tbl[i].grant});
      check($sformatf("vec%0d_busy", i),   {31'd0, busy},   {31'd0, tbl[i].busy});
      if (tbl[i].busy) check($sformatf("vec%0d_owner", i), {30'd0, owner}, {30'd0, tbl[i].owner});
    end

    // All requesting: fixed-length tenures in rotation, one turnaround between.
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("rot%0d_turn", t), {28'd0, grant}, 32'h0);
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        check($sformatf("rot%0d_c%0d_grant", t, c), {28'd0, grant}, 32'(1 << (t % N)));
        check($sformatf("rot%0d_c%0d_owner", t, c), {30'd0, owner}, 32'(t % N));
      end
    end

    // Asynchronous reset while requester 3 owns the bus.
    do_reset();
    req = 4'b1000;
    tick();
    check("r3_turn", {28'd0, grant}, 32'h0);
    tick();
    check("r3_grant", {28'd0, grant}, 32'h8);
    check("r3_owner", {30'd0, owner}, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("arst_switch", {28'd0, switch}, 32'hF);
    check("arst_grant",  {28'd0, grant},  32'h0);
    check("arst_busy",   {31'd0, busy},   32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rearb_turn", {28'd0, grant}, 32'h0);
    tick();
    check("rearb_grant", {28'd0, grant}, 32'h8);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [N-1:0] r;
      logic [N-1:0] eg;
      r = req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      req = r;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
      eg = (m_mode == 2) ? N'(1) << m_owner : '0;
      check("rnd_grant",  {28'd0, grant},  {28'd0, eg});
      check("rnd_switch", {28'd0, switch}, {28'd0, ~eg});
      check("rnd_busy",   {31'd0, busy},   {31'd0, (m_mode == 2)});
      if (m_mode == 2) check("rnd_owner", {30'd0, owner}, 32'(m_owner));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire
